reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have these parameters, one per line:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, register address width; DEPTH = 2**ADDR_W.
- ZERO_R0, 1, when 1 register 0 is hardwired to zero.
- BYPASS, 1, when 1 same-cycle write data is forwarded to the read ports.
REQ-002 The block SHALL have these ports, one per line:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- rs, input, ADDR_W, read port 1 address.
- rt, input, ADDR_W, read port 2 address.
- rd, input, ADDR_W, write address.
- RW, input, DATA_W, write data.
- wr, input, 1, write enable; also serves as the writeback that clears busy.
- alloc, input, 1, mark register alloc_addr busy (pending producer).
- alloc_addr, input, ADDR_W, register to mark busy.
- Rout1, output, DATA_W, data for rs.
- Rout2, output, DATA_W, data for rt.
- rs_busy, output, 1, rs has a pending producer.
- rt_busy, output, 1, rt has a pending producer.
- busy_cnt, output, ADDR_W+1, number of busy registers.
REQ-003 The clock SHALL be one clock, clk; the reset SHALL be asynchronous and active-low, named rst.

Function
REQ-004 Storage SHALL be DEPTH x DATA_W registers and a DEPTH-bit busy vector.
REQ-005 A write SHALL occur at the rising clk edge when wr=1: reg[rd] <= RW.
REQ-006 Reads SHALL be combinational: Rout1 = reg[rs] and Rout2 = reg[rt], with zero added latency.
REQ-007 When BYPASS=1, wr=1 and rd==rs, Rout1 SHALL equal RW in the same cycle; the same rule applies to Rout2 with rt.
REQ-008 When BYPASS=0, a written value SHALL appear on the read ports only from the cycle after the write edge.
REQ-009 When ZERO_R0=1, writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0 with no bypass, and busy[0] SHALL never set.
REQ-010 When ZERO_R0=0, register 0 SHALL behave like any other register.
REQ-011 At a clk edge with alloc=1, busy[alloc_addr] SHALL be set to 1.
REQ-012 At a clk edge with wr=1, busy[rd] SHALL be cleared to 0.
REQ-013 When alloc=1 and wr=1 address the same register at the same edge, the data SHALL be written and busy SHALL end at 1 (alloc wins).
REQ-014 rs_busy SHALL be busy[rs], except it SHALL read 0 when BYPASS=1, wr=1, rd==rs, and not (alloc=1 with alloc_addr==rs).
REQ-015 rt_busy SHALL follow the same rule as rs_busy, using rt.
REQ-016 Allocating a register that is already busy SHALL leave it busy with no error.
REQ-017 A write to a register that is not busy SHALL be performed normally.
REQ-018 busy_cnt SHALL be a registered population count of the busy vector, updated on the same edge as the busy vector, range 0..DEPTH with no wrap.
REQ-019 Inputs rs and rt SHALL have no effect on state.

Reset
REQ-020 While rst=0, asynchronously and independently of clk, all registers SHALL clear to 0, the busy vector SHALL clear to 0, and busy_cnt SHALL be 0.
REQ-021 During reset, Rout1, Rout2, rs_busy and rt_busy SHALL be 0, with bypass suppressed.
REQ-022 An alloc or wr pending when rst asserts mid-operation SHALL be discarded.
REQ-023 Operation SHALL resume at the first rising edge after rst returns to 1.

Verification
REQ-024 Reset clear: rst=0 for 70 ns, then read rs=2, rt=5 -> Rout1=0, Rout2=0, busy_cnt=0.
REQ-025 Write then read: wr=1, rd=2, RW=16'h03E8 for one edge, then rs=2 -> Rout1=16'h03E8; also check that with BYPASS=1 and rs=2 in the write cycle, Rout1=16'h03E8 before the edge.
REQ-026 R0 hardwired (ZERO_R0=1): wr=1, rd=0, RW=16'h05DC, then rs=0 -> Rout1=0 in the write cycle and after it.
REQ-027 Scoreboard: alloc=1, alloc_addr=5 for one edge -> rs=5 gives rs_busy=1 and busy_cnt=1; then wr=1, rd=5, RW=16'h09C4 -> rs_busy=0 in that cycle (BYPASS=1), and after the edge busy_cnt=0 and Rout1=16'h09C4.
REQ-028 Collision: alloc=1, alloc_addr=6 and wr=1, rd=6, RW=16'h0BB8 at the same edge -> reg6=16'h0BB8, rt=6 gives rt_busy=1, busy_cnt=1.
REQ-029 Reset mid-operation: alloc registers 3 and 8, write 16'h0DAC to reg 8, then pulse rst=0 between edges -> all busy bits, busy_cnt and reg8 read 0 immediately, without any clock edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard and combinational read ports.
// Same-cycle write data can be forwarded to the read ports, and register 0 can be hardwired to zero.
module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] RW,
  input  logic              wr,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic [DATA_W-1:0] Rout1,
  output logic [DATA_W-1:0] Rout2,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  // Forwarding hits only when the write is real (not a discarded r0 write) and reset is released.
  function automatic logic fwd_hit(input logic [ADDR_W-1:0] a);
    return (BYPASS != 0) && rst && wr && (rd == a) && !is_r0(a);
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    if (!rst || is_r0(a)) return '0;
    if (fwd_hit(a))       return RW;
    return regs_q[a];
  endfunction

  // A same-cycle writeback hides busy unless the same edge re-allocates the register.
  function automatic logic busy_port(input logic [ADDR_W-1:0] a);
    if (!rst)                                      return 1'b0;
    if (fwd_hit(a) && !(alloc && alloc_addr == a)) return 1'b0;
    return busy_q[a];
  endfunction

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr && !is_r0(rd)) regs_d[rd] = RW;
    if (wr)               busy_d[rd] = 1'b0;
    if (alloc)            busy_d[alloc_addr] = 1'b1;
    if (ZERO_R0 != 0)     busy_d[0] = 1'b0;
    busy_cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    Rout1   = read_port(rs);
    Rout2   = read_port(rt);
    rs_busy = busy_port(rs);
    rt_busy = busy_port(rt);
  end

  assign busy_cnt = busy_cnt_q;

endmodule
